// File: rtl/sysid_pkg.sv
// sysid_pkg: register offsets, CTRL bit positions and a byte-lane merge helper
// shared by the system-ID peripheral files.
package sysid_pkg;

  localparam int OFS_SYSID     = 0;
  localparam int OFS_TIMESTAMP = 1;
  localparam int OFS_VERSION   = 2;
  localparam int OFS_SCRATCH   = 3;
  localparam int OFS_UPTIME_LO = 4;
  localparam int OFS_UPTIME_HI = 5;
  localparam int OFS_CTRL      = 6;
  localparam int OFS_RSVD      = 7;

  localparam int CTRL_CLR_BIT  = 0;

  // Merge a write into an existing word, touching only the enabled byte lanes.
  function automatic logic [31:0] apply_be(input logic [31:0] old_word,
                                           input logic [31:0] new_word,
                                           input logic [3:0]  be);
    logic [31:0] merged;
    merged = old_word;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) merged[b*8 +: 8] = new_word[b*8 +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/sysid_if.sv
// sysid_if: Avalon-MM bus bundle for the system-ID peripheral (no waitrequest).
interface sysid_if #(
  parameter int ADDR_W = 3
) ();
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [31:0]       writedata;
  logic [3:0]        byteenable;
  logic [31:0]       readdata;
  logic              readdatavalid;

  modport master (
    output address, read, write, writedata, byteenable,
    input  readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output readdata, readdatavalid
  );
endinterface

// File: rtl/sysid_uptime.sv
// sysid_uptime: prescaled 64-bit uptime counter with a high-word shadow that is
// captured whenever the low word is read, so LO/HI come from one snapshot.
module sysid_uptime #(
  parameter int TICK_DIV = 50
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        tick_clr,
  input  logic        snap,
  output logic [31:0] lo,
  output logic [31:0] hi_shadow
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0] r_presc;
  logic [63:0]   r_cnt;
  logic [31:0]   r_hi_shadow;
  logic          w_wrap;

  assign w_wrap    = (r_presc == PW'(TICK_DIV - 1));
  assign lo        = r_cnt[31:0];
  assign hi_shadow = r_hi_shadow;

  // Prescaler/counter/shadow; clear has priority over a tick in the same cycle.
  always_ff @(posedge clock) begin
    if (reset || tick_clr) begin
      r_presc     <= '0;
      r_cnt       <= '0;
      r_hi_shadow <= '0;
    end else begin
      r_presc <= w_wrap ? '0 : r_presc + 1'b1;
      if (w_wrap) r_cnt <= r_cnt + 64'd1;
      if (snap)   r_hi_shadow <= r_cnt[63:32];
    end
  end

endmodule

// File: rtl/sysid_regs.sv
// sysid_regs: system-ID Avalon-MM slave (ID, timestamp, version, scratch and
// optional uptime counter). Define SYSID_UPTIME_EN to build the uptime counter,
// UPTIME_LO/HI and CTRL; otherwise offsets 4-6 read 0 and ignore writes.
module sysid_regs
  import sysid_pkg::*;
#(
  parameter logic [31:0] SYSTEM_ID    = 32'h0000_0391,
  parameter logic [31:0] TIMESTAMP    = 32'h0,
  parameter logic [31:0] VERSION      = 32'h0001_0000,
  parameter int          ADDR_W       = 3,
  parameter int          READ_LATENCY = 1,
  parameter int          TICK_DIV     = 50
) (
  input logic     clock,
  input logic     reset,
  sysid_if.slave  bus
);

  if (READ_LATENCY < 1 || READ_LATENCY > 3 || TICK_DIV < 1) begin : g_param_check
    $error("sysid_regs: READ_LATENCY must be 1..3 and TICK_DIV >= 1");
  end

  logic [ADDR_W-1:0] w_addr;
  logic              w_rd;
  logic              w_wr;
  logic [31:0]       w_rdata;
  logic [31:0]       w_up_lo;
  logic [31:0]       w_up_hi;
  logic [31:0]       r_scratch;

  assign w_addr = bus.address;
  assign w_rd   = bus.read;
  // A read in the same cycle wins; the write is dropped.
  assign w_wr   = bus.write & ~bus.read;

`ifdef SYSID_UPTIME_EN
  logic w_clr;
  logic w_snap;

  assign w_snap = w_rd && (w_addr == ADDR_W'(OFS_UPTIME_LO));
  assign w_clr  = w_wr && (w_addr == ADDR_W'(OFS_CTRL)) &&
                  bus.byteenable[0] && bus.writedata[CTRL_CLR_BIT];

  sysid_uptime #(
    .TICK_DIV (TICK_DIV)
  ) u_uptime (
    .clock     (clock),
    .reset     (reset),
    .tick_clr  (w_clr),
    .snap      (w_snap),
    .lo        (w_up_lo),
    .hi_shadow (w_up_hi)
  );
`else
  assign w_up_lo = '0;
  assign w_up_hi = '0;
`endif

  // SCRATCH register, byte-lane masked writes.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_scratch <= '0;
    end else if (w_wr && (w_addr == ADDR_W'(OFS_SCRATCH))) begin
      r_scratch <= apply_be(r_scratch, bus.writedata, bus.byteenable);
    end
  end

  // Read decode; CTRL, reserved and out-of-map offsets read 0.
  always_comb begin
    w_rdata = '0;
    case (w_addr)
      ADDR_W'(OFS_SYSID):     w_rdata = SYSTEM_ID;
      ADDR_W'(OFS_TIMESTAMP): w_rdata = TIMESTAMP;
      ADDR_W'(OFS_VERSION):   w_rdata = VERSION;
      ADDR_W'(OFS_SCRATCH):   w_rdata = r_scratch;
      ADDR_W'(OFS_UPTIME_LO): w_rdata = w_up_lo;
      ADDR_W'(OFS_UPTIME_HI): w_rdata = w_up_hi;
      default:                w_rdata = '0;
    endcase
  end

  // Read pipeline: data only advances with a valid beat, so the last stage
  // holds the most recent read value while readdatavalid is low.
  for (genvar gi = 0; gi < READ_LATENCY; gi++) begin : g_stage
    logic        r_vld;
    logic [31:0] r_dat;
    logic        w_in_vld;
    logic [31:0] w_in_dat;

    if (gi == 0) begin : g_first
      assign w_in_vld = w_rd;
      assign w_in_dat = w_rdata;
    end else begin : g_next
      assign w_in_vld = g_stage[gi-1].r_vld;
      assign w_in_dat = g_stage[gi-1].r_dat;
    end

    // One pipeline stage; reset discards any read in flight.
    always_ff @(posedge clock) begin
      if (reset) begin
        r_vld <= 1'b0;
        r_dat <= '0;
      end else begin
        r_vld <= w_in_vld;
        if (w_in_vld) r_dat <= w_in_dat;
      end
    end
  end

  assign bus.readdatavalid = g_stage[READ_LATENCY-1].r_vld;
  assign bus.readdata      = g_stage[READ_LATENCY-1].r_dat;

endmodule
